// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//
// APB requester for the apb_exe_unit_* slaves. Takes one command at a time
// from a valid/ready command port, runs a SETUP -> ACCESS transfer to the
// selected slave, waits for PREADY, and returns the result on a one-cycle
// response strobe. An ACCESS-phase timeout stops a hung slave from locking
// up the master. A binary slave index selects one of the SEL_WIDTH one-hot
// PSEL lines.
//
// Ports:
//   i_PCLK, i_PRESET          clock, synchronous active-high reset
//   i_req_valid/o_req_ready   command handshake (ready only in IDLE)
//   i_req_write/idx/addr/wdata command fields, sampled on valid && ready
//   o_rsp_valid               one-cycle response strobe
//   o_rsp_rdata/err           captured PRDATA (reads only) / PSLVERR
//   o_rsp_timeout             ACCESS phase aborted without PREADY
//   o_rsp_badidx              index out of range; no bus cycle was issued
//   o_PSEL..o_PWDATA          APB requester outputs
//   i_PREADY/i_PRDATA/i_PSLVERR APB completer inputs
// ---------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int SEL_WIDTH  = 3,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2,   // 2**IDX_WIDTH must be >= SEL_WIDTH
  parameter int TIMEOUT    = 16   // legal range 2..255
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESET,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [IDX_WIDTH-1:0]  i_req_idx,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [3:0]            o_rsp_err,
  output logic                  o_rsp_timeout,
  output logic                  o_rsp_badidx,
  output logic [SEL_WIDTH-1:0]  o_PSEL,
  output logic                  o_PENABLE,
  output logic                  o_PWRITE,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic [DATA_WIDTH-1:0] o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [DATA_WIDTH-1:0] i_PRDATA,
  input  logic [3:0]            i_PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [7:0]         TIMEOUT_CNT = 8'(TIMEOUT);
  // One bit wider than the index so that SEL_WIDTH == 2**IDX_WIDTH fits.
  localparam logic [IDX_WIDTH:0] SEL_LIMIT   = (IDX_WIDTH + 1)'(SEL_WIDTH);

  state_t                  state_reg;
  logic [7:0]              wait_cnt_reg;
  logic                    req_ready_reg;
  logic                    rsp_valid_reg;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic [3:0]              rsp_err_reg;
  logic                    rsp_timeout_reg;
  logic                    rsp_badidx_reg;
  logic [SEL_WIDTH-1:0]    psel_reg;
  logic                    penable_reg;
  logic                    pwrite_reg;
  logic [ADDR_WIDTH-1:0]   paddr_reg;
  logic [DATA_WIDTH-1:0]   pwdata_reg;

  logic [SEL_WIDTH-1:0]    sel_decode;
  logic                    idx_bad;
  logic                    accept;

  // Binary index -> one-hot select. At most one bit can match, so PSEL is
  // never multi-hot; an out-of-range index decodes to all zeros.
  generate
    for (genvar gi = 0; gi < SEL_WIDTH; gi++) begin : g_sel_decode
      assign sel_decode[gi] = (i_req_idx == IDX_WIDTH'(gi));
    end
  endgenerate

  assign idx_bad = ({1'b0, i_req_idx} >= SEL_LIMIT);
  assign accept  = req_ready_reg && i_req_valid;

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= '0;
      req_ready_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= '0;
      rsp_timeout_reg <= 1'b0;
      rsp_badidx_reg  <= 1'b0;
      psel_reg        <= '0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
    end else begin
      // Response fields are only meaningful for the single RESP cycle;
      // they are cleared every edge and loaded only when entering RESP.
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= '0;
      rsp_timeout_reg <= 1'b0;
      rsp_badidx_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            req_ready_reg <= 1'b0;
            if (idx_bad) begin
              // No bus cycle at all: PSEL and the bus fields stay untouched.
              state_reg      <= RESP;
              rsp_valid_reg  <= 1'b1;
              rsp_badidx_reg <= 1'b1;
            end else begin
              // The APB output registers double as the command latch, so
              // later changes on i_req_* cannot disturb the transfer.
              state_reg  <= SETUP;
              psel_reg   <= sel_decode;
              paddr_reg  <= i_req_addr;
              pwrite_reg <= i_req_write;
              pwdata_reg <= i_req_write ? i_req_wdata : '0;
            end
          end else begin
            // Also raises ready on the first edge after reset release.
            req_ready_reg <= 1'b1;
          end
        end

        SETUP: begin
          state_reg    <= ACCESS;
          penable_reg  <= 1'b1;
          wait_cnt_reg <= 8'd1;
        end

        ACCESS: begin
          // PREADY is checked before the timeout so a slave that answers
          // in the final allowed cycle still completes normally.
          if (i_PREADY) begin
            state_reg     <= RESP;
            psel_reg      <= '0;
            penable_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= i_PSLVERR;
            rsp_rdata_reg <= pwrite_reg ? '0 : i_PRDATA;
          end else if (wait_cnt_reg == TIMEOUT_CNT) begin
            state_reg       <= RESP;
            psel_reg        <= '0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_timeout_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        RESP: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end

        default: begin
          state_reg     <= IDLE;
          psel_reg      <= '0;
          penable_reg   <= 1'b0;
          req_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready   = req_ready_reg;
  assign o_rsp_valid   = rsp_valid_reg;
  assign o_rsp_rdata   = rsp_rdata_reg;
  assign o_rsp_err     = rsp_err_reg;
  assign o_rsp_timeout = rsp_timeout_reg;
  assign o_rsp_badidx  = rsp_badidx_reg;
  assign o_PSEL        = psel_reg;
  assign o_PENABLE     = penable_reg;
  assign o_PWRITE      = pwrite_reg;
  assign o_PADDR       = paddr_reg;
  assign o_PWDATA      = pwdata_reg;

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
//
// Self-checking bench for apb_cmd_master with the default parameters
// (3 slaves, 2-bit address, 8-bit data, TIMEOUT = 16). Table-driven
// transactions plus hand-written reset sequences.
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;

  logic       clk;
  logic       srst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_idx;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [3:0] rsp_err;
  logic       rsp_timeout;
  logic       rsp_badidx;
  logic [2:0] psel;
  logic       penable;
  logic       pwrite;
  logic [1:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic [7:0] prdata;
  logic [3:0] pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  apb_cmd_master #(
    .SEL_WIDTH (3),
    .ADDR_WIDTH(2),
    .DATA_WIDTH(8),
    .IDX_WIDTH (2),
    .TIMEOUT   (16)
  ) dut (
    .i_PCLK       (clk),
    .i_PRESET     (srst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_idx    (req_idx),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_rsp_timeout(rsp_timeout),
    .o_rsp_badidx (rsp_badidx),
    .o_PSEL       (psel),
    .o_PENABLE    (penable),
    .o_PWRITE     (pwrite),
    .o_PADDR      (paddr),
    .o_PWDATA     (pwdata),
    .i_PREADY     (pready),
    .i_PRDATA     (prdata),
    .i_PSLVERR    (pslverr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       write;
    logic [1:0] idx;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata;
    logic [3:0] pslverr;
    int         waits;      // ACCESS cycles with PREADY low before it rises
    logic [2:0] exp_psel;
    logic [7:0] exp_rdata;
    logic [3:0] exp_err;
    logic       exp_to;
    logic       exp_bad;
    int         exp_lat;    // cycles from accept edge to rsp_valid
    int         exp_pen;    // number of cycles with PENABLE high
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input int id);
    int lat;
    int pen;
    int acc;
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("ready_before_cmd", req_ready, 1);

    req_valid = 1'b1;
    req_write = v.write;
    req_idx   = v.idx;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    step();                       // accept edge k; now in cycle k+1
    req_valid = 1'b0;
    req_write = ~v.write;         // scrambled: must have no effect
    req_idx   = v.idx ^ 2'b01;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    lat = 1;
    pen = 0;
    acc = 0;

    if (!v.exp_bad) begin
      chk("setup_psel",    psel,    v.exp_psel);
      chk("setup_penable", penable, 0);
      chk("setup_paddr",   paddr,   v.addr);
      chk("setup_pwrite",  pwrite,  v.write);
      chk("setup_pwdata",  pwdata,  v.write ? v.wdata : 8'h00);
    end

    while (!rsp_valid && lat < 40) begin
      if (penable) begin
        acc++;
        pen++;
        chk("access_psel",   psel,   v.exp_psel);
        chk("access_paddr",  paddr,  v.addr);
        chk("access_pwrite", pwrite, v.write);
        chk("access_pwdata", pwdata, v.write ? v.wdata : 8'h00);
        pready = (acc == v.waits + 1);
      end else begin
        chk("penable_without_psel_or_setup", psel, v.exp_psel);
        pready = 1'b0;
      end
      prdata  = pready ? v.prdata  : 8'hFF;
      pslverr = pready ? v.pslverr : 4'hF;
      step();
      lat++;
    end
    pready  = 1'b0;
    prdata  = 8'hFF;
    pslverr = 4'hF;

    chk("rsp_valid",   rsp_valid,   1);
    chk("rsp_latency", lat,         v.exp_lat);
    chk("penable_cnt", pen,         v.exp_pen);
    chk("rsp_rdata",   rsp_rdata,   v.exp_rdata);
    chk("rsp_err",     rsp_err,     v.exp_err);
    chk("rsp_timeout", rsp_timeout, v.exp_to);
    chk("rsp_badidx",  rsp_badidx,  v.exp_bad);
    chk("rsp_psel",    psel,        0);
    chk("rsp_penable", penable,     0);
    $display("txn %0d: wr=%0d idx=%0d lat=%0d pen=%0d rdata=%02h err=%0h to=%0d bad=%0d",
             id, v.write, v.idx, lat, pen, rsp_rdata, rsp_err, rsp_timeout, rsp_badidx);
    step();
    chk("ready_after_rsp",  req_ready, 1);
    chk("rsp_valid_cleared", rsp_valid, 0);
    chk("rsp_fields_cleared", {rsp_rdata, rsp_err, rsp_timeout, rsp_badidx}, 0);
  endtask

  initial begin
    int   guard;
    logic seen_rsp;
    vec_t v;

    //          wr    idx    addr   wdata  prdata pslverr wt  psel    rdata  err  to    bad  lat pen
    vecs[0] = '{1'b1, 2'd0, 2'b01, 8'h1A, 8'h77, 4'h0,   0,  3'b001, 8'h00, 4'h0, 1'b0, 1'b0, 3, 1};
    vecs[1] = '{1'b0, 2'd0, 2'b00, 8'h00, 8'h34, 4'h0,   0,  3'b001, 8'h34, 4'h0, 1'b0, 1'b0, 3, 1};
    vecs[2] = '{1'b0, 2'd1, 2'b10, 8'h00, 8'hA5, 4'h0,   3,  3'b010, 8'hA5, 4'h0, 1'b0, 1'b0, 6, 4};
    vecs[3] = '{1'b1, 2'd2, 2'b11, 8'h5C, 8'h00, 4'h2,   0,  3'b100, 8'h00, 4'h2, 1'b0, 1'b0, 3, 1};
    vecs[4] = '{1'b0, 2'd1, 2'b01, 8'h00, 8'h66, 4'h0, 255,  3'b010, 8'h00, 4'h0, 1'b1, 1'b0, 18, 16};
    vecs[5] = '{1'b0, 2'd2, 2'b10, 8'h00, 8'hC3, 4'h9,  15,  3'b100, 8'hC3, 4'h9, 1'b0, 1'b0, 18, 16};
    vecs[6] = '{1'b1, 2'd3, 2'b11, 8'hFF, 8'h00, 4'h0,   0,  3'b000, 8'h00, 4'h0, 1'b0, 1'b1, 1, 0};
    vecs[7] = '{1'b0, 2'd0, 2'b11, 8'h00, 8'h81, 4'hF,   1,  3'b001, 8'h81, 4'hF, 1'b0, 1'b0, 4, 2};

    srst      = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_idx   = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b0;
    prdata    = 8'hFF;
    pslverr   = 4'hF;

    // Reset state: every output zero, ready included.
    step();
    step();
    chk("reset_ready",   req_ready, 0);
    chk("reset_outputs", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_badidx,
                          psel, penable, pwrite, paddr, pwdata}, 0);
    srst = 1'b0;
    step();
    chk("ready_after_release", req_ready, 1);
    $display("reset: ready=%0d psel=%0d", req_ready, psel);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], i);
    end

    // Reset during ACCESS: bus drops at that edge, no response follows.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_idx   = 2'd1;
    req_addr  = 2'b10;
    step();                       // accept
    req_valid = 1'b0;
    step();                       // ACCESS cycle 1
    chk("mid_access_penable", penable, 1);
    chk("mid_access_psel",    psel,    3'b010);
    step();                       // ACCESS cycle 2
    srst = 1'b1;
    step();
    chk("rst_mid_psel",    psel,      0);
    chk("rst_mid_penable", penable,   0);
    chk("rst_mid_ready",   req_ready, 0);
    chk("rst_mid_rsp",     rsp_valid, 0);
    srst = 1'b0;
    step();
    chk("rst_mid_ready_release", req_ready, 1);
    seen_rsp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid || penable || (psel != 0)) seen_rsp = 1'b1;
      step();
    end
    chk("rst_mid_no_activity", seen_rsp, 0);
    $display("reset mid-access: ready=%0d psel=%0d", req_ready, psel);

    // The master must be fully usable after the abort.
    v = vecs[2];
    run_txn(v, 8);

    guard = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case a bounded loop is somehow bypassed.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB requester that sits directly upstream of the apb_exe_unit_* slaves.
- Accepts one command at a time from a simple valid/ready command port and runs a full APB SETUP→ACCESS transfer to the selected slave.
- Waits for PREADY, then returns read data plus the slave's 4-bit error code on a one-cycle response strobe.
- Converts the SEL_BIT-per-slave select scheme into a binary slave index, and guards against hung slaves with an ACCESS-phase timeout.

Parameters:
- SEL_WIDTH, 3: number of PSEL lines (one per exe unit).
- ADDR_WIDTH, 2: PADDR width (slave operation/register select).
- DATA_WIDTH, 8: PWDATA/PRDATA width.
- IDX_WIDTH, 2: width of the binary slave index; must satisfy 2**IDX_WIDTH >= SEL_WIDTH.
- TIMEOUT, 16: maximum ACCESS cycles without PREADY before abort; legal range 2..255.

Ports:
- i_PCLK  in  1  bus clock; all logic on the rising edge.
- i_PRESET  in  1  synchronous, active-high reset.
- i_req_valid  in  1  command present.
- o_req_ready  out  1  master can accept a command (high only in IDLE).
- i_req_write  in  1  1 = write, 0 = read.
- i_req_idx  in  IDX_WIDTH  binary target slave index.
- i_req_addr  in  ADDR_WIDTH  target address.
- i_req_wdata  in  DATA_WIDTH  write data.
- o_rsp_valid  out  1  one-cycle response strobe.
- o_rsp_rdata  out  DATA_WIDTH  captured PRDATA.
- o_rsp_err  out  4  captured PSLVERR.
- o_rsp_timeout  out  1  transfer aborted by timeout.
- o_rsp_badidx  out  1  index out of range; no bus cycle was issued.
- o_PSEL  out  SEL_WIDTH  one-hot slave select.
- o_PENABLE  out  1  ACCESS phase.
- o_PWRITE  out  1  transfer direction.
- o_PADDR  out  ADDR_WIDTH  address.
- o_PWDATA  out  DATA_WIDTH  write data.
- i_PREADY  in  1  slave ready.
- i_PRDATA  in  DATA_WIDTH  slave read data.
- i_PSLVERR  in  4  slave error code.

Behaviour:
- Reset: i_PRESET sampled high at a rising edge forces IDLE and zeroes every output, including o_req_ready. o_req_ready rises on the first edge after reset is released.
- Reset mid-transfer: aborts immediately. PSEL/PENABLE go to 0 at the same edge and no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - o_req_ready=1, PSEL=0, PENABLE=0.
  - PADDR/PWDATA/PWRITE hold their last values.
  - On i_req_valid=1 the command is latched.
  - If i_req_idx >= SEL_WIDTH: go to RESP with badidx=1, err=0, rdata=0. No PSEL is ever asserted.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle):
  - o_PSEL = 1<<idx, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latch.
  - For reads, PWDATA is driven as 0.
  - Next state is ACCESS.
- ACCESS:
  - PENABLE=1. PSEL, PADDR, PWRITE and PWDATA are held stable.
  - The wait counter starts at 1 in the first ACCESS cycle.
  - i_PREADY=1 at an edge: capture i_PSLVERR, and capture i_PRDATA for reads (rdata=0 for writes), then go to RESP.
  - Counter == TIMEOUT with PREADY still low: go to RESP with timeout=1, err=0, rdata=0.
  - If PREADY and the timeout coincide at the same edge, PREADY wins (normal completion).
- RESP (1 cycle):
  - o_rsp_valid=1 together with rdata/err/timeout/badidx, which are all valid only in this cycle.
  - PSEL=0, PENABLE=0.
  - Next state is IDLE; the response fields return to 0 with o_rsp_valid.
- Latency: command accepted at edge k → SETUP in cycle k+1 → ACCESS in k+2. With zero wait states, o_rsp_valid is high in k+3 and o_req_ready is high again in k+4. Each PREADY wait state adds 1 cycle.
- Command port: i_req_* is sampled only on valid&&ready. Changes to i_req_* during SETUP/ACCESS have no effect.
- Bus rule: o_PSEL is never multi-hot. PENABLE is never 1 while PSEL=0.

Test Plan:
1. Write then read, zero waits:
   - Stimulus: write idx=0, addr=2'b01, wdata=8'h1A; then read idx=0, addr=2'b00; slave PREADY=1, PRDATA=8'h34.
   - Write: SETUP shows PSEL=3'b001, PENABLE=0; ACCESS shows PENABLE=1, PWDATA=8'h1A; rsp_valid 3 cycles after accept.
   - Read: rsp_rdata=8'h34, rsp_err=0.
2. Wait states:
   - Stimulus: read idx=1; PREADY held low for 3 ACCESS cycles, then high with PRDATA=8'hA5.
   - Response: PSEL=3'b010 stable for all ACCESS cycles; rsp_valid 6 cycles after accept; rdata=8'hA5.
3. Slave error:
   - Stimulus: write idx=2 with PSLVERR=4'b0010 at PREADY.
   - Response: PSEL=3'b100; rsp_err=4'b0010, timeout=0.
4. Timeout:
   - Stimulus: PREADY stuck at 0.
   - Response: PENABLE high for exactly 16 cycles; rsp_valid with timeout=1 and err=0; ready again the next cycle.
   - PREADY rising exactly in ACCESS cycle 16 produces a normal completion (timeout=0).
5. Bad index:
   - Stimulus: idx=3 with SEL_WIDTH=3.
   - Response: PSEL stays 0 throughout; rsp_valid 1 cycle after accept with badidx=1.
6. Reset mid-ACCESS:
   - Stimulus: assert i_PRESET during ACCESS.
   - Response: PSEL/PENABLE=0 at that edge; no rsp_valid; ready=1 on the first edge after release.
